// File: rtl/tx_arbiter_sched.sv
// -----------------------------------------------------------------------------
// tx_arbiter_sched
//
// Round-robin scheduler sharing one parallel-load serial transmitter between
// NREQ requesters. A winning requester's word is captured into DIN, the
// transmitter is loaded and started, and the transfer is closed with a
// one-cycle XFER_DONE (normal completion) or XFER_ERR (timeout) pulse.
//
// Ports
//   CLK            system clock, rising edge
//   RESET          asynchronous, active-high reset
//   REQ            per-requester request levels
//   REQ_DATA       packed request words, requester i at [i*DATA_W +: DATA_W]
//   GRANT          one-hot pulse, coincides with PARALLEL_LOAD
//   XFER_DONE      one-cycle pulse, transfer of CUR_ID completed
//   XFER_ERR       one-cycle pulse, transfer of CUR_ID aborted by timeout
//   CUR_ID         requester being served, stable from GRANT to DONE/ERR
//   BUSY           high whenever a transaction is in progress
//   DIN            word presented to the transmitter
//   PARALLEL_LOAD  transmitter load strobe (one cycle)
//   START_TX       transmitter start request, held until TX_BUSY is seen
//   TX_BUSY        transmitter busy flag
//   TX_DONE        transmitter one-cycle completion pulse
// -----------------------------------------------------------------------------
module tx_arbiter_sched #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NREQ-1:0]            REQ,
    input  logic [NREQ*DATA_W-1:0]     REQ_DATA,
    output logic [NREQ-1:0]            GRANT,
    output logic                       XFER_DONE,
    output logic                       XFER_ERR,
    output logic [$clog2(NREQ)-1:0]    CUR_ID,
    output logic                       BUSY,
    output logic [DATA_W-1:0]          DIN,
    output logic                       PARALLEL_LOAD,
    output logic                       START_TX,
    input  logic                       TX_BUSY,
    input  logic                       TX_DONE
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_FIN
    } state_t;

    state_t              state_q,   state_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [ID_W-1:0]     cur_id_q,  cur_id_d;
    logic [DATA_W-1:0]   din_q,     din_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                err_q,     err_d;
    logic [NREQ-1:0]     grant_q,   grant_d;

    // Round-robin winner: first requester found searching upward from
    // last_id+1, wrapping modulo NREQ.
    logic                req_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(last_id_q) + k) % NREQ);
            if (!req_found && REQ[cand]) begin
                req_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
        cur_id_d  = cur_id_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        grant_d   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    state_d   = S_LOAD;
                    cur_id_d  = win_id;
                    // Updated even if this transfer later aborts, so a
                    // failing requester cannot starve the others.
                    last_id_d = win_id;
                    din_d     = REQ_DATA[int'(win_id) * DATA_W +: DATA_W];
                    err_d     = 1'b0;
                    grant_d   = NREQ'(1) << win_id;
                end
            end

            S_LOAD: begin
                state_d = S_START;
                cnt_d   = '0;
            end

            // TX_DONE is deliberately ignored here: only a completion that
            // follows an observed TX_BUSY belongs to this transfer.
            S_START: begin
                if (TX_BUSY) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle spent here; counter is
                    // parked at TIMEOUT rather than wrapping.
                    state_d = S_FIN;
                    err_d   = 1'b1;
                    cnt_d   = CNT_W'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT: begin
                if (TX_DONE) begin
                    state_d = S_FIN;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                    cnt_d   = CNT_W'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            last_id_q <= ID_W'(NREQ - 1);
            cur_id_q  <= '0;
            din_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            cur_id_q  <= cur_id_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            grant_q   <= grant_d;
        end
    end

    // Strobes are decoded from the state register, so they fall as soon as
    // RESET forces the state back to IDLE.
    assign GRANT         = grant_q;
    assign CUR_ID        = cur_id_q;
    assign DIN           = din_q;
    assign BUSY          = (state_q != S_IDLE);
    assign PARALLEL_LOAD = (state_q == S_LOAD);
    assign START_TX      = (state_q == S_START);
    assign XFER_DONE     = (state_q == S_FIN) && !err_q;
    assign XFER_ERR      = (state_q == S_FIN) &&  err_q;

endmodule
